wrr_arbiter: RTL

Parametrised weighted round-robin arbiter granting one of N requesters for a programmable number of consecutive cycles (time slice). Per-client slice lengths come from a run-time configuration port instead of fixed constants, and ownership hands over back-to-back with no idle bubble. Optionally, an owner that drops its request releases early. It sits between N bus masters and a shared resource port and drives a registered one-hot grant.

---
 rtl/wrr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: run-time per-client time slices, zero-bubble handover.
// Optional early release when the owner drops req: define WRR_EARLY_RELEASE_EN.
module wrr_arbiter #(
    parameter int N        = 4,
    parameter int TS_WIDTH = 4,
    parameter int IDW      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*TS_WIDTH-1:0] slice_cfg,
    output logic [N-1:0]          grant,
    output logic                  grant_valid,
    output logic [IDW-1:0]        grant_id,
    output logic                  grant_last
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [TS_WIDTH-1:0] cnt_q, cnt_d;
    logic [TS_WIDTH-1:0] slice_q, slice_d;
    logic [N-1:0]        grant_q, grant_d;

    logic [TS_WIDTH-1:0] cfg_arr [N];
    logic [IDW-1:0]      sel_ptr;
    logic [IDW-1:0]      scan_idx;
    logic [IDW-1:0]      win_id;
    logic                win_found;
    logic [TS_WIDTH-1:0] win_slice;
    logic                slice_done;
    logic                owner_drop;
    logic                end_cycle;

    // Mod-N increment; valid for non-power-of-two N.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        wrap_inc = (int'(v) == N - 1) ? '0 : v + 1'b1;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_cfg
        assign cfg_arr[k] = slice_cfg[k*TS_WIDTH +: TS_WIDTH];
    end

    assign slice_done = (cnt_q == slice_q);

`ifdef WRR_EARLY_RELEASE_EN
    assign owner_drop = ~req[owner_q];
`else
    assign owner_drop = 1'b0;
`endif

    assign end_cycle = (state_q == BUSY) && (slice_done || owner_drop);

    // At an end cycle the search starts just past the owner.
    assign sel_ptr = (state_q == BUSY) ? wrap_inc(owner_q) : ptr_q;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = sel_ptr;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // A zero slice is promoted to one cycle.
    assign win_slice = (cfg_arr[win_id] == '0) ?
                       TS_WIDTH'(1) : cfg_arr[win_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            slice_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            slice_q <= slice_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (end_cycle && !win_found) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        slice_d = slice_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_id;
                    cnt_d   = TS_WIDTH'(1);
                    slice_d = win_slice;
                    grant_d = N'(1) << win_id;
                end
            end
            BUSY: begin
                if (end_cycle) begin
                    ptr_d = sel_ptr;
                    if (win_found) begin
                        owner_d = win_id;
                        cnt_d   = TS_WIDTH'(1);
                        slice_d = win_slice;
                        grant_d = N'(1) << win_id;
                    end else begin
                        cnt_d   = '0;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = (state_q == BUSY) ? owner_q : '0;
    assign grant_last  = (state_q == BUSY) && slice_done;

endmodule
